// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer with a one-word holding register.
// Bits arrive MSB first; a completed word is presented on out together with
// out_valid and held until the consumer acknowledges it. A word that completes
// while the previous one is still unacknowledged is dropped and flagged on
// the sticky overrun output.
module sipo_deserializer #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_in,
  input  logic                 in,
  input  logic                 frame_clr,
  input  logic                 out_ack,
  input  logic                 ovr_clr,
  output logic [N-1:0]         out,
  output logic                 out_valid,
  output logic                 overrun,
  output logic [$clog2(N)-1:0] bit_cnt
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  logic [N-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  out_q, out_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;

  logic          accept;
  logic          complete;
  logic [N-1:0]  word;

  // frame_clr takes priority over a bit offered in the same cycle
  assign accept   = shift_in & ~frame_clr;
  assign complete = accept & (cnt_q == LAST_BIT);
  assign word     = {sreg_q[N-2:0], in};

  // Shift register and bit counter next state
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (frame_clr) begin
      sreg_d = '0;
      cnt_d  = '0;
    end else if (accept) begin
      sreg_d = word;
      cnt_d  = complete ? '0 : cnt_q + CW'(1);
    end
  end

  // Holding register handshake and overrun detection; a new overrun wins over ovr_clr
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (ovr_clr) begin
      ovr_d = 1'b0;
    end
    if (complete) begin
      if (!valid_q || out_ack) begin
        out_d   = word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ack) begin
      valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;
  assign bit_cnt   = cnt_q;

endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 SHALL have parameter N, default 8, meaning word width in bits (N >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low; low forces reset state.
REQ-004 SHALL have port shift_in  input  1  serial bit valid; 1 = sample in this edge.
REQ-005 SHALL have port in  input  1  serial data bit, MSB of each word first.
REQ-006 SHALL have port frame_clr  input  1  synchronous frame restart; discards a partial word.
REQ-007 SHALL have port out_ack  input  1  consumer acknowledge of the held word.
REQ-008 SHALL have port ovr_clr  input  1  synchronous clear of overrun flag.
REQ-009 SHALL have port out  output  N  last completed parallel word.
REQ-010 SHALL have port out_valid  output  1  out holds an unacknowledged word.
REQ-011 SHALL have port overrun  output  1  sticky; a completed word was dropped.
REQ-012 SHALL have port bit_cnt  output  clog2(N)  bits collected in the current partial word.

Function
REQ-013 SHALL hold a shift register sreg[N-1:0] and counter bit_cnt (0..N-1); all outputs registered.
REQ-014 SHALL, on an edge with shift_in=1 and frame_clr=0, load sreg <= {sreg[N-2:0], in}.
REQ-015 SHALL increment bit_cnt on each accepted bit, wrapping N-1 -> 0 on the completing bit.
REQ-016 SHALL treat the bit accepted with bit_cnt=N-1 as the word's LSB; completed word = {sreg[N-2:0], in}.
REQ-017 SHALL, on completion with out_valid=0, load out with the completed word and set out_valid=1 at that same edge (word visible 0 cycles after last bit edge).
REQ-018 SHALL clear out_valid on an edge where out_valid=1 and out_ack=1 and no completion occurs; out keeps its value.
REQ-019 SHALL ignore out_ack while out_valid=0.
REQ-020 SHALL, on completion with out_valid=1 and out_ack=1 in the same cycle, load the new word and keep out_valid=1; overrun unaffected.
REQ-021 SHALL, on completion with out_valid=1 and out_ack=0, drop the new word, keep out unchanged, keep out_valid=1, set overrun=1.
REQ-022 SHALL hold state (sreg, bit_cnt) when shift_in=0.
REQ-023 SHALL, on frame_clr=1, set bit_cnt=0 and sreg=0 and ignore shift_in that cycle; out, out_valid, overrun unaffected.
REQ-024 SHALL keep overrun=1 until ovr_clr=1; if ovr_clr and a new overrun event coincide, overrun SHALL remain 1 (set wins).
REQ-025 SHALL accept back-to-back words with no idle cycle between the last bit of one and the first bit of the next.

Reset
REQ-026 SHALL, while rst=0, immediately force sreg=0, bit_cnt=0, out=0, out_valid=0, overrun=0, independent of clk.
REQ-027 SHALL, on rst asserted mid-word, discard the partial word; first accepted bit after release is a new MSB.
REQ-028 SHALL resume normal operation on the first rising clk edge after rst returns high.

Verification
REQ-029 SHALL cover: N=8, shift 8'hDD MSB-first on 8 consecutive edges -> after 8th edge out=8'hDD, out_valid=1, bit_cnt=0; out_ack one cycle -> out_valid=0.
REQ-030 SHALL cover: 8'h2E then 8'h0A back-to-back, out_ack pulsed in the cycle of 8'h0A's last bit -> out=8'h0A, out_valid=1, overrun=0.
REQ-031 SHALL cover: 8'h80 completed, no ack, then 8'h0A completed -> out=8'h80, out_valid=1, overrun=1; ovr_clr -> overrun=0.
REQ-032 SHALL cover: 3 bits shifted, frame_clr, then 8'hDD -> out=8'hDD, no partial-word contamination.
REQ-033 SHALL cover: rst low asynchronously (between edges) at bit_cnt=5 with out_valid=1 -> all outputs 0 immediately; next full word captured correctly.
REQ-034 SHALL cover: shift_in gapped (random 0-cycles between bits) for 8'hA5 -> out=8'hA5 identical to ungapped result.
